// File: rtl/mips_uart_if.sv
// mips_uart_if: device-controller side of the MIPS789 UART.
//   din/txd_ld   : byte and one-cycle load strobe for the transmitter
//   rxd_ft       : level-sensitive clear of rxd_rdy / rx_ovr
//   txd_busy     : transmitter is sending a frame
//   rxd_rdy/dout : received byte is held in dout
//   rx_ovr       : sticky overrun, rx_ferr : one-cycle framing-error pulse
// master = device controller, slave = UART.
interface mips_uart_if;
   logic [7:0] din;
   logic       txd_ld;
   logic       rxd_ft;
   logic       txd_busy;
   logic       rxd_rdy;
   logic [7:0] dout;
   logic       rx_ovr;
   logic       rx_ferr;

   modport master (
      output din, txd_ld, rxd_ft,
      input  txd_busy, rxd_rdy, dout, rx_ovr, rx_ferr
   );

   modport slave (
      input  din, txd_ld, rxd_ft,
      output txd_busy, rxd_rdy, dout, rx_ovr, rx_ferr
   );
endinterface

// File: rtl/mips_uart.sv
// mips_uart: 8N1 UART with one transmitter and one mid-bit sampling
// receiver sharing a single baud divisor.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   ser_rxd   : serial receive pin (asynchronous, idle 1)
//   ser_txd   : serial transmit pin (idle 1)
//   bus       : controller side (din, txd_ld, rxd_ft, txd_busy, rxd_rdy,
//               dout, rx_ovr, rx_ferr), see mips_uart_if
// Baud counters load a cycle count N and expire on the N-th cycle after
// the load (count reaches 1), so a load of BAUD_DIV gives one bit time.
module mips_uart #(
   parameter int BAUD_DIV = 434,
   parameter int HALF_DIV = BAUD_DIV / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ser_rxd,
   output logic       ser_txd,
   mips_uart_if.slave bus
);
   localparam int            CW      = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] BAUD_LD = CW'(BAUD_DIV);
   localparam logic [CW-1:0] HALF_LD = CW'(HALF_DIV);
   localparam logic [CW-1:0] ONE     = CW'(1);

   // ---------------- transmitter ----------------
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

   tx_state_t     t_st;
   logic [CW-1:0] t_cnt;
   logic [2:0]    t_bit;
   logic [7:0]    t_sr;
   logic          txd_q;
   logic          busy_q;
   logic          t_exp;

   assign t_exp        = (t_cnt == ONE);
   assign ser_txd      = txd_q;
   assign bus.txd_busy = busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_st   <= T_IDLE;
         t_cnt  <= '0;
         t_bit  <= '0;
         t_sr   <= '0;
         txd_q  <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         case (t_st)
            T_IDLE: begin
               if (bus.txd_ld) begin
                  t_sr   <= bus.din;
                  t_cnt  <= BAUD_LD;
                  txd_q  <= 1'b0;
                  busy_q <= 1'b1;
                  t_st   <= T_START;
               end
            end
            T_START: begin
               if (t_exp) begin
                  t_cnt <= BAUD_LD;
                  t_bit <= '0;
                  txd_q <= t_sr[0];
                  t_st  <= T_DATA;
               end else begin
                  t_cnt <= t_cnt - ONE;
               end
            end
            T_DATA: begin
               if (t_exp) begin
                  t_cnt <= BAUD_LD;
                  if (t_bit == 3'd7) begin
                     txd_q <= 1'b1;
                     t_st  <= T_STOP;
                  end else begin
                     t_bit <= t_bit + 3'd1;
                     txd_q <= t_sr[t_bit + 3'd1];
                  end
               end else begin
                  t_cnt <= t_cnt - ONE;
               end
            end
            T_STOP: begin
               if (t_exp) begin
                  // A load arriving as busy falls chains straight into the
                  // next start bit, with no idle cycle on the line.
                  if (bus.txd_ld) begin
                     t_sr  <= bus.din;
                     t_cnt <= BAUD_LD;
                     txd_q <= 1'b0;
                     t_st  <= T_START;
                  end else begin
                     busy_q <= 1'b0;
                     t_st   <= T_IDLE;
                  end
               end else begin
                  t_cnt <= t_cnt - ONE;
               end
            end
            default: t_st <= T_IDLE;
         endcase
      end
   end

   // ---------------- receiver ----------------
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

   logic          rx_m;
   logic          rxd_s;
   rx_state_t     r_st;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_sr;
   logic          r_exp;
   logic          r_done;
   logic [7:0]    dout_q;
   logic          rdy_q;
   logic          ovr_q;
   logic          ferr_q;

   assign r_exp       = (r_cnt == ONE);
   assign r_done      = (r_st == R_STOP) && r_exp && rxd_s;
   assign bus.dout    = dout_q;
   assign bus.rxd_rdy = rdy_q;
   assign bus.rx_ovr  = ovr_q;
   assign bus.rx_ferr = ferr_q;

   // Two-stage synchronizer; reset to the idle level so no false start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m  <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rx_m  <= ser_rxd;
         rxd_s <= rx_m;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_st   <= R_IDLE;
         r_cnt  <= '0;
         r_bit  <= '0;
         r_sr   <= '0;
         ferr_q <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         case (r_st)
            R_IDLE: begin
               if (!rxd_s) begin
                  r_cnt <= HALF_LD;
                  r_st  <= R_START;
               end
            end
            R_START: begin
               if (r_exp) begin
                  if (rxd_s) begin
                     r_st <= R_IDLE;      // glitch, not a start bit
                  end else begin
                     r_cnt <= BAUD_LD;
                     r_bit <= '0;
                     r_st  <= R_DATA;
                  end
               end else begin
                  r_cnt <= r_cnt - ONE;
               end
            end
            R_DATA: begin
               if (r_exp) begin
                  r_sr  <= {rxd_s, r_sr[7:1]};
                  r_cnt <= BAUD_LD;
                  if (r_bit == 3'd7) r_st <= R_STOP;
                  else               r_bit <= r_bit + 3'd1;
               end else begin
                  r_cnt <= r_cnt - ONE;
               end
            end
            R_STOP: begin
               if (r_exp) begin
                  if (rxd_s) begin
                     r_st <= R_IDLE;
                  end else begin
                     ferr_q <= 1'b1;
                     r_st   <= R_WAIT;
                  end
               end else begin
                  r_cnt <= r_cnt - ONE;
               end
            end
            // Hold off until the line goes high so a held break cannot
            // look like a stream of new start bits.
            R_WAIT: if (rxd_s) r_st <= R_IDLE;
            default: r_st <= R_IDLE;
         endcase
      end
   end

   // Status flags: rxd_ft clears, a completing byte sets (set wins), and a
   // byte landing on an unread one raises the sticky overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q <= '0;
         rdy_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else if (r_done) begin
         dout_q <= r_sr;
         rdy_q  <= 1'b1;
         if (rdy_q && !bus.rxd_ft) ovr_q <= 1'b1;
         else if (bus.rxd_ft)      ovr_q <= 1'b0;
      end else if (bus.rxd_ft) begin
         rdy_q <= 1'b0;
         ovr_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mips_uart.sv
module tb_mips_uart;
   localparam int B = 8;
   localparam int H = B / 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd_drv = 1'b1;
   logic loop = 1'b0;
   logic ser_rxd;
   logic ser_txd;

   mips_uart_if bus ();

   assign ser_rxd = loop ? ser_txd : rxd_drv;

   mips_uart #(.BAUD_DIV(B)) dut (
      .clk     (clk),
      .rst     (rst),
      .ser_rxd (ser_rxd),
      .ser_txd (ser_txd),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int ferr_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // TX: a frame is the 10-bit word {1, data, 0} sent LSB first, each bit
   // B cycles; tx_left counts the busy cycles still to go.
   // RX: timestamps relative to the start detection on the synchronized line.
   int         tx_left;
   logic [9:0] tx_frame;
   logic       s1, s2;
   bit         rx_act, rx_wait;
   int         rx_off;
   logic [7:0] rx_byte;
   logic       m_rdy, m_ovr, m_ferr;
   logic [7:0] m_dout;

   initial begin
      logic s, done, prev_rdy;
      int j;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            tx_left = 0; tx_frame = '1;
            s1 = 1; s2 = 1; rx_act = 0; rx_wait = 0; rx_off = 0; rx_byte = 0;
            m_rdy = 0; m_ovr = 0; m_ferr = 0; m_dout = 0;
         end else begin
            if ((tx_left <= 1) && bus.txd_ld) begin
               tx_left  = 10 * B;
               tx_frame = {1'b1, bus.din, 1'b0};
            end else if (tx_left > 0) begin
               tx_left--;
            end

            s = s2; s2 = s1; s1 = ser_rxd;
            done = 0; m_ferr = 0;
            if (rx_wait) begin
               if (s) rx_wait = 0;
            end else if (!rx_act) begin
               if (!s) begin rx_act = 1; rx_off = 0; end
            end else begin
               rx_off++;
               if (rx_off == H) begin
                  if (s) rx_act = 0;
               end else if (rx_off > H && (rx_off - H) % B == 0) begin
                  j = (rx_off - H) / B;
                  if (j <= 8) rx_byte[j-1] = s;
                  else begin
                     rx_act = 0;
                     if (s) done = 1;
                     else begin m_ferr = 1; rx_wait = 1; end
                  end
               end
            end

            prev_rdy = m_rdy;
            if (bus.rxd_ft) begin m_rdy = 0; m_ovr = 0; end
            if (done) begin
               if (prev_rdy && !bus.rxd_ft) m_ovr = 1;
               m_rdy  = 1;
               m_dout = rx_byte;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      int idx;
      logic exp_txd;
      forever begin
         @(negedge clk);
         if (!rst) begin
            idx = (10 * B - tx_left) / B;
            exp_txd = (tx_left == 0) ? 1'b1 : tx_frame[idx];
            chk("ser_txd", ser_txd, exp_txd);
            chk("txd_busy", bus.txd_busy, tx_left != 0);
            chk("rxd_rdy", bus.rxd_rdy, m_rdy);
            chk("dout", bus.dout, m_dout);
            chk("rx_ovr", bus.rx_ovr, m_ovr);
            chk("rx_ferr", bus.rx_ferr, m_ferr);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (bus.rx_ferr === 1'b1) ferr_cnt++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic pulse_ld(input logic [7:0] d);
      bus.din = d;
      bus.txd_ld = 1'b1;
      cyc();
      bus.txd_ld = 1'b0;
   endtask

   // Drive one frame on ser_rxd; rxd_ft is high on cycle ft_cyc (if < 10*B).
   // The line is left at the stop-bit level.
   task automatic rx_frame(input logic [7:0] d, input logic stopb, input int ft_cyc);
      logic [9:0] bits;
      bits = {stopb, d, 1'b0};
      for (int i = 0; i < 10 * B; i++) begin
         rxd_drv = bits[i / B];
         bus.rxd_ft = (i == ft_cyc);
         cyc();
      end
      bus.rxd_ft = 1'b0;
   endtask

   task automatic ft_pulse();
      bus.rxd_ft = 1'b1;
      cyc();
      bus.rxd_ft = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [9:0] pat;
      int busy_cyc;
      int f0;
      bus.din = 8'h00;
      bus.txd_ld = 1'b0;
      bus.rxd_ft = 1'b0;

      // reset state
      repeat (3) cyc();
      chk("rst_txd", ser_txd, 1);
      chk("rst_busy", bus.txd_busy, 0);
      chk("rst_rdy", bus.rxd_rdy, 0);
      chk("rst_dout", bus.dout, 0);
      chk("rst_ovr", bus.rx_ovr, 0);
      chk("rst_ferr", bus.rx_ferr, 0);
      rst = 1'b0;
      repeat (3) cyc();

      // TX frame A5: line pattern 0,1,0,1,0,0,1,0,1,1 and 80 busy cycles
      pat = 10'b1101001010;
      pulse_ld(8'hA5);
      chk("tx_start_fall", ser_txd, 0);
      busy_cyc = 0;
      for (int i = 0; i < 90; i++) begin
         if (bus.txd_busy) busy_cyc++;
         if (i < 80 && i % B == H) chk("tx_a5_bit", ser_txd, pat[i / B]);
         cyc();
      end
      chk("tx_busy_len", busy_cyc, 80);

      // load while busy is ignored, load as busy falls chains with no gap
      pulse_ld(8'h3C);
      repeat (10) cyc();
      pulse_ld(8'hFF);
      repeat (68) cyc();
      chk("tx_stop_3c", ser_txd, 1);
      pulse_ld(8'h96);
      chk("b2b_start", ser_txd, 0);
      chk("b2b_busy", bus.txd_busy, 1);
      repeat (85) cyc();

      // loopback 5A
      loop = 1'b1;
      pulse_ld(8'h5A);
      for (int i = 0; i < 100 && !bus.rxd_rdy; i++) cyc();
      chk("lb_rdy", bus.rxd_rdy, 1);
      chk("lb_dout", bus.dout, 8'h5A);
      chk("lb_before_stop_end", bus.txd_busy, 1);
      ft_pulse();
      chk("lb_ft_clear", bus.rxd_rdy, 0);
      repeat (20) cyc();
      loop = 1'b0;
      repeat (5) cyc();

      // overrun, then clear coinciding with completion (set wins)
      rx_frame(8'h11, 1'b1, -1);
      rx_frame(8'h22, 1'b1, -1);
      repeat (3) cyc();
      chk("ovr_dout", bus.dout, 8'h22);
      chk("ovr_flag", bus.rx_ovr, 1);
      rx_frame(8'h33, 1'b1, 2 + H + 9 * B);
      chk("sim_rdy", bus.rxd_rdy, 1);
      chk("sim_ovr", bus.rx_ovr, 0);
      chk("sim_dout", bus.dout, 8'h33);
      ft_pulse();
      repeat (5) cyc();

      // framing error, held break, rearm
      f0 = ferr_cnt;
      rx_frame(8'h7E, 1'b0, -1);
      rxd_drv = 1'b0;
      repeat (40) cyc();
      rxd_drv = 1'b1;
      repeat (10) cyc();
      chk("ferr_pulses", ferr_cnt - f0, 1);
      chk("ferr_dout", bus.dout, 8'h33);
      chk("ferr_rdy", bus.rxd_rdy, 0);
      rx_frame(8'hA3, 1'b1, -1);
      repeat (3) cyc();
      chk("rearm_dout", bus.dout, 8'hA3);
      chk("rearm_rdy", bus.rxd_rdy, 1);
      ft_pulse();

      // 2-cycle glitch: false start, no flags
      rxd_drv = 1'b0;
      repeat (2) cyc();
      rxd_drv = 1'b1;
      repeat (20) cyc();
      chk("glitch_rdy", bus.rxd_rdy, 0);
      chk("glitch_dout", bus.dout, 8'hA3);
      chk("glitch_ferr", ferr_cnt - f0, 1);

      // random direct RX with concurrent random TX loads
      fork
         begin
            for (int k = 0; k < 25; k++) begin
               rx_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 120));
               rxd_drv = 1'b1;
               repeat ($urandom_range(1, 12)) cyc();
               if ($urandom_range(0, 4) == 0) begin
                  rxd_drv = 1'b0;
                  repeat ($urandom_range(1, 3)) cyc();
                  rxd_drv = 1'b1;
                  repeat (10) cyc();
               end
            end
         end
         begin
            repeat (120) begin
               bus.din = 8'($urandom);
               bus.txd_ld = ($urandom_range(0, 2) == 0);
               cyc();
               bus.txd_ld = 1'b0;
               repeat ($urandom_range(0, 30)) cyc();
            end
         end
      join
      for (int i = 0; i < 200 && bus.txd_busy; i++) cyc();
      repeat (20) cyc();

      // random loopback traffic
      loop = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         bus.din = 8'($urandom);
         bus.txd_ld = ($urandom_range(0, 39) == 0);
         bus.rxd_ft = ($urandom_range(0, 29) == 0);
         cyc();
      end
      bus.txd_ld = 1'b0;
      bus.rxd_ft = 1'b0;
      for (int i = 0; i < 200 && bus.txd_busy; i++) cyc();
      chk("lb_drain", bus.txd_busy, 0);
      repeat (30) cyc();
      loop = 1'b0;
      repeat (5) cyc();

      // reset in the middle of a TX frame and an RX frame
      rx_frame(8'h55, 1'b1, -1);
      repeat (2) cyc();
      chk("pre_rst_rdy", bus.rxd_rdy, 1);
      bus.din = 8'hC3;
      pat = {1'b1, 8'hC3, 1'b0};
      for (int i = 0; i < 5 * B + 3; i++) begin
         bus.txd_ld = (i == 0);
         rxd_drv = pat[i / B];
         cyc();
      end
      bus.txd_ld = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_txd", ser_txd, 1);
      chk("mid_rst_busy", bus.txd_busy, 0);
      chk("mid_rst_rdy", bus.rxd_rdy, 0);
      chk("mid_rst_dout", bus.dout, 0);
      rxd_drv = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      repeat (5) cyc();
      rx_frame(8'hC3, 1'b1, -1);
      repeat (3) cyc();
      chk("post_rst_dout", bus.dout, 8'hC3);
      chk("post_rst_rdy", bus.rxd_rdy, 1);
      chk("post_rst_ovr", bus.rx_ovr, 0);
      repeat (5) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
